ubuffer_fifo: RTL



---
 rtl/ubuffer_fifo_pkg.sv | 14 +
 rtl/ubuffer_fifo_if.sv | 31 +++
 rtl/ubuffer_fifo_ram.sv | 31 +++
 rtl/ubuffer_fifo.sv | 96 +++++++++
 4 files changed

// File: rtl/ubuffer_fifo_pkg.sv
// Shared constants and helpers for the receive-side byte buffer.
// Default geometry is an 8-bit word, 16 entries deep.
// ubuf_cnt_w() sizes an occupancy counter that can hold 0..DEPTH.
package ubuffer_pkg;

  localparam int UBUF_DATA_W = 8;
  localparam int UBUF_DEPTH  = 16;

  // Occupancy needs one bit more than the pointer so that DEPTH fits.
  function automatic int ubuf_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ubuffer_fifo_if.sv
// Write strobe, read handshake and status bundle of the receive buffer.
// slave: the FIFO itself; master: the receiver/consumer side driving it.
// count is sized with the package helper so that it can reach DEPTH.
interface ubuffer_fifo_if #(
  parameter int DATA_W = ubuffer_pkg::UBUF_DATA_W,
  parameter int DEPTH  = ubuffer_pkg::UBUF_DEPTH
);

  logic                                       r_data;
  logic [DATA_W-1:0]                          datain;
  logic [DATA_W-1:0]                          dataout;
  logic                                       ready;
  logic                                       rd_ack;
  logic                                       wr_pulse;
  logic [ubuffer_pkg::ubuf_cnt_w(DEPTH)-1:0]  count;
  logic                                       full;
  logic                                       almost_full;
  logic                                       overflow;
  logic                                       ovf_clr;

  modport slave (
    input  r_data, datain, rd_ack, ovf_clr,
    output dataout, ready, wr_pulse, count, full, almost_full, overflow
  );

  modport master (
    output r_data, datain, rd_ack, ovf_clr,
    input  dataout, ready, wr_pulse, count, full, almost_full, overflow
  );

endinterface

// File: rtl/ubuffer_fifo_ram.sv
// DEPTH x DATA_W register array with one write port and one async read port.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the caller decides when writing is legal.
module ubuffer_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store on write enable; reset wipes every entry so the head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ubuffer_fifo.sv
// Receive-side word FIFO with first-word-fall-through read and status flags.
// Latency: a word written on one edge is on dataout (ready=1) right after it.
// Backpressure: none upstream; a write while full (no pop) sets sticky
// overflow and is dropped, or with UBUF_DROP_OLDEST_EN evicts the oldest word.
module ubuffer_fifo
  import ubuffer_pkg::*;
#(
  parameter int DATA_W   = UBUF_DATA_W,
  parameter int DEPTH    = UBUF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic             clk,
  input  logic             rst,
  ubuffer_fifo_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ubuf_cnt_w(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          pulse_q;

  logic          full_w;
  logic          pop;
  logic          ovf_set;
  logic          wr_en;
  logic          rd_adv;

  assign full_w = (count_q == CW'(DEPTH));

  // Decide which pointers move this cycle and the resulting occupancy.
  always_comb begin
    pop     = (count_q != '0) && bus.rd_ack;
    ovf_set = bus.r_data && full_w && !pop;
`ifdef UBUF_DROP_OLDEST_EN
    // A full write with no pop evicts the head, so the write always lands.
    wr_en   = bus.r_data;
    rd_adv  = pop || ovf_set;
`else
    // A full write with no pop is discarded; a same-cycle pop frees a slot.
    wr_en   = bus.r_data && (!full_w || pop);
    rd_adv  = pop;
`endif
    count_d = count_q;
    if (wr_en && !rd_adv) count_d = count_q + 1'b1;
    else if (!wr_en && rd_adv) count_d = count_q - 1'b1;
  end

  // Pointer, occupancy and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      pulse_q <= wr_en;
    end
  end

  // Sticky overflow; a new overflow beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ovf_q <= 1'b0;
    else if (ovf_set)      ovf_q <= 1'b1;
    else if (bus.ovf_clr)  ovf_q <= 1'b0;
  end

  ubuffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.datain),
    .raddr (rd_ptr),
    .rdata (bus.dataout)
  );

  assign bus.count       = count_q;
  assign bus.ready       = (count_q != '0);
  assign bus.full        = full_w;
  assign bus.almost_full = (count_q >= CW'(AF_LEVEL));
  assign bus.overflow    = ovf_q;
  assign bus.wr_pulse    = pulse_q;

endmodule
